// File: rtl/bp_cfg_pkg.sv
// Shared definitions for the boot-time configuration sequencer: config
// register map, sequencer state encoding and the config write bundle.

`ifndef BP_CFG_PKG_SV
`define BP_CFG_PKG_SV

// Config write bundle, sized by the instantiating module like the other
// common structs of the codebase.
`define BP_CFG_DECLARE_WRITE_S(core_w, addr_w, data_w) \
  typedef struct packed {                              \
    logic [core_w-1:0] core_id;                        \
    logic [addr_w-1:0] addr;                           \
    logic [data_w-1:0] data;                           \
  } bp_cfg_write_s

package bp_cfg_pkg;

  // Per-core config register map
  localparam logic [15:0] bp_cfg_addr_freeze_gp     = 16'h0000;
  localparam logic [15:0] bp_cfg_addr_core_id_gp    = 16'h0001;
  localparam logic [15:0] bp_cfg_addr_cce_id_gp     = 16'h0002;
  localparam logic [15:0] bp_cfg_addr_instr_base_gp = 16'h8000;

  typedef enum logic [2:0] {
    e_cfg_idle,
    e_cfg_freeze,
    e_cfg_core_id,
    e_cfg_cce_id,
    e_cfg_rom_req,
    e_cfg_instr,
    e_cfg_unfreeze,
    e_cfg_done
  } bp_cfg_state_e;

  // Index width for n items; never below one bit so single-item
  // configurations still get a real port.
  function automatic int unsigned bp_cfg_ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`endif

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear and up together restart the
// count at up_i. Reset is active-high, as elsewhere in the bsg library.

module bsg_counter_clear_up #(
  parameter int unsigned max_val_p  = 1,
  parameter int unsigned init_val_p = 0,
  parameter int unsigned width_p    = (max_val_p > 0) ? $clog2(max_val_p + 1) : 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  // Count register: reset, then clear, then increment
  // NOTE: state registers use non-blocking assignment so every flop in the
  // design samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_o <= width_p'(init_val_p);
    else if (clear_i)
      count_o <= width_p'(up_i);
    else if (up_i)
      count_o <= count_o + width_p'(1);
  end

endmodule

// File: rtl/bp_cfg_sequencer.sv
// Boot-time configuration sequencer. Walks every core, writing freeze,
// core id, CCE id and the CCE instruction RAM image fetched from a
// synchronous boot ROM, then releases freeze on each core in order.

module bp_cfg_sequencer
  import bp_cfg_pkg::*;
#(
  parameter int unsigned num_core_p              = 1,
  parameter int unsigned num_cce_instr_ram_els_p = 256,
  parameter int unsigned cfg_addr_width_p        = 16,
  parameter int unsigned cfg_data_width_p        = 64
) (
  input  logic                                                  clk_i,
  input  logic                                                  reset_n_i,
  input  logic                                                  start_i,
  output logic                                                  busy_o,
  output logic                                                  done_o,
  output logic [bp_cfg_ptr_width(num_cce_instr_ram_els_p)-1:0]  rom_addr_o,
  input  logic [cfg_data_width_p-1:0]                           rom_data_i,
  output logic                                                  cfg_v_o,
  input  logic                                                  cfg_ready_i,
  output logic [bp_cfg_ptr_width(num_core_p)-1:0]               cfg_core_id_o,
  output logic [cfg_addr_width_p-1:0]                           cfg_addr_o,
  output logic [cfg_data_width_p-1:0]                           cfg_data_o
);

  localparam int unsigned core_id_width_lp   = bp_cfg_ptr_width(num_core_p);
  localparam int unsigned instr_idx_width_lp = bp_cfg_ptr_width(num_cce_instr_ram_els_p);

  localparam logic [cfg_addr_width_p-1:0] freeze_addr_lp     = cfg_addr_width_p'(bp_cfg_addr_freeze_gp);
  localparam logic [cfg_addr_width_p-1:0] core_id_addr_lp    = cfg_addr_width_p'(bp_cfg_addr_core_id_gp);
  localparam logic [cfg_addr_width_p-1:0] cce_id_addr_lp     = cfg_addr_width_p'(bp_cfg_addr_cce_id_gp);
  localparam logic [cfg_addr_width_p-1:0] instr_base_addr_lp = cfg_addr_width_p'(bp_cfg_addr_instr_base_gp);

  `BP_CFG_DECLARE_WRITE_S(core_id_width_lp, cfg_addr_width_p, cfg_data_width_p);

  bp_cfg_state_e                 state_r;
  logic                          cfg_v_r;
  logic [cfg_addr_width_p-1:0]   cfg_addr_r;
  logic [cfg_data_width_p-1:0]   cfg_data_r;
  logic [instr_idx_width_lp-1:0] rom_addr_r;
  logic                          busy_r;
  logic                          done_r;
  logic                          instr_fresh_r;  // first INSTR cycle: ROM word is on rom_data_i
  logic [cfg_data_width_p-1:0]   instr_hold_r;   // ROM word kept across config stalls

  logic [core_id_width_lp-1:0]   core_cnt;
  logic [instr_idx_width_lp-1:0] instr_cnt;
  logic                          core_up, core_clr, instr_up, instr_clr;

  logic transfer, core_last, instr_last, start_accept;
  bp_cfg_write_s cfg_w;

  assign transfer     = cfg_v_r & cfg_ready_i;
  assign core_last    = (core_cnt == core_id_width_lp'(num_core_p - 1));
  assign instr_last   = (instr_cnt == instr_idx_width_lp'(num_cce_instr_ram_els_p - 1));
  assign start_accept = start_i & ((state_r == e_cfg_idle) | (state_r == e_cfg_done));

  bsg_counter_clear_up #(
    .max_val_p (num_core_p - 1),
    .width_p   (core_id_width_lp)
  ) core_counter (
    .clk_i   (clk_i),
    .reset_i (~reset_n_i),
    .clear_i (core_clr),
    .up_i    (core_up),
    .count_o (core_cnt)
  );

  bsg_counter_clear_up #(
    .max_val_p (num_cce_instr_ram_els_p - 1),
    .width_p   (instr_idx_width_lp)
  ) instr_counter (
    .clk_i   (clk_i),
    .reset_i (~reset_n_i),
    .clear_i (instr_clr),
    .up_i    (instr_up),
    .count_o (instr_cnt)
  );

  // Counter steering: terminal compares decide between increment and clear
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    core_up   = 1'b0;
    core_clr  = start_accept;
    instr_up  = 1'b0;
    instr_clr = start_accept;
    if (transfer) begin
      unique case (state_r)
        e_cfg_cce_id: instr_clr = 1'b1;
        e_cfg_instr: begin
          if (!instr_last) begin
            instr_up = 1'b1;
          end else begin
            instr_clr = 1'b1;
            core_up   = !core_last;
            core_clr  = core_last;
          end
        end
        e_cfg_unfreeze: begin
          core_up  = !core_last;
          core_clr = core_last;
        end
        default: ;
      endcase
    end
  end

  // Sequencer FSM with registered handshake, address and status outputs
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r       <= e_cfg_idle;
      cfg_v_r       <= 1'b0;
      cfg_addr_r    <= '0;
      cfg_data_r    <= '0;
      rom_addr_r    <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      instr_fresh_r <= 1'b0;
      instr_hold_r  <= '0;
    end else begin
      instr_fresh_r <= 1'b0;
      if (instr_fresh_r)
        instr_hold_r <= rom_data_i;

      unique case (state_r)
        e_cfg_idle, e_cfg_done: begin
          if (start_i) begin
            state_r    <= e_cfg_freeze;
            cfg_v_r    <= 1'b1;
            cfg_addr_r <= freeze_addr_lp;
            cfg_data_r <= cfg_data_width_p'(1);
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
          end
        end
        e_cfg_freeze: begin
          if (transfer) begin
            state_r    <= e_cfg_core_id;
            cfg_addr_r <= core_id_addr_lp;
            cfg_data_r <= cfg_data_width_p'(core_cnt);
          end
        end
        e_cfg_core_id: begin
          if (transfer) begin
            state_r    <= e_cfg_cce_id;
            cfg_addr_r <= cce_id_addr_lp;
            cfg_data_r <= cfg_data_width_p'(core_cnt);
          end
        end
        e_cfg_cce_id: begin
          if (transfer) begin
            state_r    <= e_cfg_rom_req;
            cfg_v_r    <= 1'b0;
            rom_addr_r <= '0;
          end
        end
        e_cfg_rom_req: begin
          // The ROM answers next cycle; INSTR forwards it on its first cycle
          state_r       <= e_cfg_instr;
          cfg_v_r       <= 1'b1;
          cfg_addr_r    <= instr_base_addr_lp + cfg_addr_width_p'(instr_cnt);
          instr_fresh_r <= 1'b1;
        end
        e_cfg_instr: begin
          if (transfer) begin
            if (!instr_last) begin
              state_r    <= e_cfg_rom_req;
              cfg_v_r    <= 1'b0;
              rom_addr_r <= instr_cnt + instr_idx_width_lp'(1);
            end else if (!core_last) begin
              state_r    <= e_cfg_freeze;
              cfg_addr_r <= freeze_addr_lp;
              cfg_data_r <= cfg_data_width_p'(1);
            end else begin
              state_r    <= e_cfg_unfreeze;
              cfg_addr_r <= freeze_addr_lp;
              cfg_data_r <= '0;
            end
          end
        end
        e_cfg_unfreeze: begin
          if (transfer && core_last) begin
            state_r    <= e_cfg_done;
            cfg_v_r    <= 1'b0;
            cfg_addr_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
          end
        end
        default: state_r <= e_cfg_idle;
      endcase
    end
  end

  // Output bundle; instruction data bypasses the holding register on the
  // cycle the ROM word arrives
  always_comb begin
    cfg_w = '{core_id: core_cnt, addr: cfg_addr_r, data: cfg_data_r};
    if (state_r == e_cfg_instr)
      cfg_w.data = instr_fresh_r ? rom_data_i : instr_hold_r;
  end

  assign cfg_v_o       = cfg_v_r;
  assign cfg_core_id_o = cfg_w.core_id;
  assign cfg_addr_o    = cfg_w.addr;
  assign cfg_data_o    = cfg_w.data;
  assign rom_addr_o    = rom_addr_r;
  assign busy_o        = busy_r;
  assign done_o        = done_r;

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Bench for bp_cfg_sequencer: a two-core/four-word instance and a
// one-core/one-word instance, each with a synchronous ROM model. Expected
// write streams come from a list-based model of the boot sequence.

module tb_bp_cfg_sequencer;

  localparam int nc_a  = 2;
  localparam int els_a = 4;

  typedef struct {
    int          core;
    int          addr;
    logic [63:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, start_b, ready_a, ready_b, ready_rand;

  logic        busy_a, done_a, v_a;
  logic [1:0]  rom_addr_a;
  logic [63:0] rom_data_a, data_a;
  logic [0:0]  core_a;
  logic [15:0] addr_a;

  logic        busy_b, done_b, v_b;
  logic [0:0]  rom_addr_b;
  logic [63:0] rom_data_b, data_b;
  logic [0:0]  core_b;
  logic [15:0] addr_b;

  logic [63:0] rom_a [els_a];
  logic [63:0] rom_b [2];

  int checks = 0;
  int errors = 0;

  wr_t got_a[$];
  wr_t got_b[$];
  wr_t exp_q[$];

  int   stall_viol = 0;
  int   done_rises_a = 0;
  logic prev_stall = 1'b0, prev_done_a = 1'b0;
  logic [0:0]  prev_core;
  logic [15:0] prev_addr;
  logic [63:0] prev_data;

  bp_cfg_sequencer #(
    .num_core_p(nc_a), .num_cce_instr_ram_els_p(els_a),
    .cfg_addr_width_p(16), .cfg_data_width_p(64)
  ) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start_a),
    .busy_o(busy_a), .done_o(done_a),
    .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a),
    .cfg_v_o(v_a), .cfg_ready_i(ready_a),
    .cfg_core_id_o(core_a), .cfg_addr_o(addr_a), .cfg_data_o(data_a)
  );

  bp_cfg_sequencer #(
    .num_core_p(1), .num_cce_instr_ram_els_p(1),
    .cfg_addr_width_p(16), .cfg_data_width_p(64)
  ) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start_b),
    .busy_o(busy_b), .done_o(done_b),
    .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b),
    .cfg_v_o(v_b), .cfg_ready_i(ready_b),
    .cfg_core_id_o(core_b), .cfg_addr_o(addr_b), .cfg_data_o(data_b)
  );

  // Synchronous boot ROMs: data follows the address by one cycle
  always @(posedge clk) begin
    rom_data_a <= rom_a[rom_addr_a];
    rom_data_b <= rom_b[rom_addr_b];
  end

  // Config sink readiness, changed just after each active edge
  always begin
    @(posedge clk);
    #1;
    ready_a = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Sink monitor: logs transfers, watches stall stability and done rises
  always @(negedge clk) begin
    if (v_a && ready_a) got_a.push_back('{core: int'(core_a), addr: int'(addr_a), data: data_a});
    if (v_b && ready_b) got_b.push_back('{core: int'(core_b), addr: int'(addr_b), data: data_b});
    if (!rst_n) begin
      prev_stall  <= 1'b0;
      prev_done_a <= 1'b0;
    end else begin
      if (prev_stall && (!v_a || core_a !== prev_core || addr_a !== prev_addr || data_a !== prev_data))
        stall_viol <= stall_viol + 1;
      if (done_a && !prev_done_a)
        done_rises_a <= done_rises_a + 1;
      prev_stall  <= v_a && !ready_a;
      prev_done_a <= done_a;
      prev_core   <= core_a;
      prev_addr   <= addr_a;
      prev_data   <= data_a;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk(input int c, input int a, input logic [63:0] d);
    wr_t w;
    w.core = c;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  // Boot sequence model: per core freeze/ids/image, then unfreeze in order
  function automatic void build_exp(input int nc, input int els, input logic [63:0] words[$]);
    exp_q.delete();
    for (int c = 0; c < nc; c++) begin
      exp_q.push_back(mk(c, 'h0000, 64'd1));
      exp_q.push_back(mk(c, 'h0001, 64'(c)));
      exp_q.push_back(mk(c, 'h0002, 64'(c)));
      for (int i = 0; i < els; i++)
        exp_q.push_back(mk(c, 'h8000 + i, words[i]));
    end
    for (int c = 0; c < nc; c++)
      exp_q.push_back(mk(c, 'h0000, 64'd0));
  endfunction

  task automatic compare_writes(input string tag, input wr_t got[$]);
    int n;
    check($sformatf("%s write count", tag), 64'(got.size()), 64'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s wr%0d core", tag, i), 64'(got[i].core), 64'(exp_q[i].core));
      check($sformatf("%s wr%0d addr", tag, i), 64'(got[i].addr), 64'(exp_q[i].addr));
      check($sformatf("%s wr%0d data", tag, i), got[i].data, exp_q[i].data);
    end
  endtask

  task automatic load_exp_a();
    logic [63:0] words[$];
    for (int i = 0; i < els_a; i++) words.push_back(rom_a[i]);
    build_exp(nc_a, els_a, words);
  endtask

  // Start dut_a at the current falling edge (that edge's cycle is 0) and
  // run to done_o, pulsing start_i again at cycles p1/p2 when positive
  task automatic run_a(input int p1, input int p2, output int first_v, output int done_at,
                       output logic busy_at1, output logic done_at1);
    got_a.delete();
    first_v  = -1;
    done_at  = -1;
    busy_at1 = 1'b0;
    done_at1 = 1'b1;
    start_a  = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      start_a = (n == p1) || (n == p2);
      if (n == 1) begin
        busy_at1 = busy_a;
        done_at1 = done_a;
      end
      if (v_a && first_v < 0) first_v = n;
      if (done_a) begin
        done_at = n;
        break;
      end
    end
    start_a = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int   fv, da, rises0, viol0, cnt;
  logic b1, d1;

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1; ready_rand = 1'b0;
    for (int i = 0; i < els_a; i++) rom_a[i] = 64'hA0 + 64'(i);
    rom_b[0] = {$urandom, $urandom};
    rom_b[1] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst cfg_v", 64'(v_a), 64'd0);
    check("rst busy", 64'(busy_a), 64'd0);
    check("rst done", 64'(done_a), 64'd0);
    check("rst core_id", 64'(core_a), 64'd0);
    check("rst addr", 64'(addr_a), 64'd0);
    check("rst data", data_a, 64'd0);
    check("rst rom_addr", 64'(rom_addr_a), 64'd0);
    check("rst b busy/v/done", {61'd0, busy_b, v_b, done_b}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sequence, sink always ready
    load_exp_a();
    rises0 = done_rises_a;
    run_a(-1, -1, fv, da, b1, d1);
    check("t1 first cfg_v cycle", 64'(fv), 64'd1);
    check("t1 done cycle", 64'(da), 64'd25);
    check("t1 busy at cycle 1", 64'(b1), 64'd1);
    check("t1 busy after done", 64'(busy_a), 64'd0);
    check("t1 done rises", 64'(done_rises_a - rises0), 64'd1);
    compare_writes("t1", got_a);

    // Restart from DONE: identical write stream
    run_a(-1, -1, fv, da, b1, d1);
    check("t2 done falls after start", 64'(d1), 64'd0);
    check("t2 done cycle", 64'(da), 64'd25);
    compare_writes("t2", got_a);

    // Random sink stalls with random ROM images
    ready_rand = 1'b1;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < els_a; i++) rom_a[i] = {$urandom, $urandom};
      load_exp_a();
      rises0 = done_rises_a;
      viol0  = stall_viol;
      run_a(-1, -1, fv, da, b1, d1);
      check($sformatf("t3.%0d reached done", it), 64'(da > 0), 64'd1);
      check($sformatf("t3.%0d stall stability", it), 64'(stall_viol - viol0), 64'd0);
      check($sformatf("t3.%0d done rises", it), 64'(done_rises_a - rises0), 64'd1);
      compare_writes($sformatf("t3.%0d", it), got_a);
    end
    ready_rand = 1'b0;
    repeat (2) @(negedge clk);

    // start_i pulses while busy are ignored
    for (int i = 0; i < els_a; i++) rom_a[i] = 64'hA0 + 64'(i);
    load_exp_a();
    rises0 = done_rises_a;
    run_a(5, 10, fv, da, b1, d1);
    check("t4 done cycle", 64'(da), 64'd25);
    check("t4 done rises", 64'(done_rises_a - rises0), 64'd1);
    compare_writes("t4", got_a);

    // Reset during core 0 image load abandons the sequence
    got_a.delete();
    start_a = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("t5 cfg_v after reset", 64'(v_a), 64'd0);
    check("t5 busy after reset", 64'(busy_a), 64'd0);
    check("t5 done after reset", 64'(done_a), 64'd0);
    cnt = got_a.size();
    check("t5 writes before reset", 64'(cnt), 64'd5);
    repeat (3) @(negedge clk);
    check("t5 no writes in reset", 64'(got_a.size()), 64'(cnt));
    rst_n = 1'b1;
    @(negedge clk);
    run_a(-1, -1, fv, da, b1, d1);
    check("t5 done cycle", 64'(da), 64'd25);
    compare_writes("t5", got_a);

    // Single core, single instruction word
    begin
      logic [63:0] words[$];
      words.push_back(rom_b[0]);
      build_exp(1, 1, words);
    end
    got_b.delete();
    da = -1;
    start_b = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b) begin
        da = n;
        break;
      end
    end
    check("t6 done cycle", 64'(da), 64'd7);
    compare_writes("t6", got_b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
